// File: rtl/irq_request_bank_if.sv
// irq_request_bank_if: request-bank bus between PIC control logic and the request register
interface irq_request_bank_if #(parameter int N = 8);
  localparam int IDW = $clog2(N);
  logic [N-1:0] irq_in, edge_mode, imr, irr, irr_masked;
  logic init_clr, ack_valid, irq_pending;
  logic [IDW-1:0] ack_id;
  modport master (output irq_in, edge_mode, imr, init_clr, ack_valid, ack_id, input irr, irr_masked, irq_pending);
  modport slave (input irq_in, edge_mode, imr, init_clr, ack_valid, ack_id, output irr, irr_masked, irq_pending);
endinterface

// File: rtl/irq_request_bank.sv
// irq_request_bank: synchronised edge/level interrupt request register with acknowledge and masking
module irq_request_bank #(
  parameter int N = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  irq_request_bank_if.slave bus
);
  localparam int IDW = $clog2(N);
  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0] prev_q, req_q, req_d, sync, rise, clr;
  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  // shift each raw line one stage further down its synchroniser chain
  always_comb begin
    sync_d[0] = bus.irq_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end
  // decode the acknowledge; out-of-range ids match no channel and are dropped
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) clr[i] = bus.ack_valid && bus.ack_id == IDW'(i);
  end
  // init_clr wins; level channels follow the line; edge channels set on rise (beating ack) else hold
  always_comb req_d = bus.init_clr ? '0 : (~bus.edge_mode & sync) | (bus.edge_mode & (rise | (req_q & ~clr)));
  // state registers; prev always tracks sync so init_clr re-arms against the current level
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      req_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync;
      req_q <= req_d;
    end
  assign bus.irr = req_q;
  assign bus.irr_masked = req_q & ~bus.imr;
  assign bus.irq_pending = |bus.irr_masked;
endmodule

// File: tb/tb_irq_request_bank.sv
// tb_irq_request_bank: vector table, hand sequences and randomized model check of irq_request_bank
module tb_irq_request_bank;
  logic clk = 0, reset = 1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  irq_request_bank_if #(.N(8)) b8();
  irq_request_bank_if #(.N(5)) b5();
  irq_request_bank #(.N(8), .SYNC_STAGES(2)) u8 (.clk(clk), .reset(reset), .bus(b8));
  irq_request_bank #(.N(5), .SYNC_STAGES(3)) u5 (.clk(clk), .reset(reset), .bus(b5));

  typedef struct {
    logic [7:0] irq, em, imr;
    logic ic, av;
    logic [2:0] aid;
    logic [7:0] e_irr, e_msk;
    logic e_pnd;
  } vec_t;
  vec_t tv[$];

  // reference: a line's level reaches the request logic two samples late, its previous value three late
  logic [7:0] hist [0:2];
  logic [7:0] m_req;
  always @(posedge clk or posedge reset) begin
    logic [7:0] nx;
    logic s, p;
    if (reset) begin
      for (int j = 0; j <= 2; j++) hist[j] <= '0;
      m_req <= '0;
    end else begin
      nx = m_req;
      for (int i = 0; i < 8; i++) begin
        s = hist[1][i];
        p = hist[2][i];
        if (b8.init_clr) nx[i] = 1'b0;
        else if (!b8.edge_mode[i]) nx[i] = s;
        else if (s && !p) nx[i] = 1'b1;
        else if (b8.ack_valid && int'(b8.ack_id) == i) nx[i] = 1'b0;
      end
      m_req <= nx;
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= b8.irq_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic [7:0] irq, em, imr, input logic ic, av, input logic [2:0] aid,
                   input logic [7:0] e_irr, e_msk, input logic e_pnd);
    tv.push_back('{irq, em, imr, ic, av, aid, e_irr, e_msk, e_pnd});
  endtask

  task automatic chk8(input string nm, input logic [7:0] e_irr, e_msk, input logic e_pnd);
    chk({nm, " irr"}, 32'(b8.irr), 32'(e_irr));
    chk({nm, " irr_masked"}, 32'(b8.irr_masked), 32'(e_msk));
    chk({nm, " irq_pending"}, 32'(b8.irq_pending), 32'(e_pnd));
  endtask

  initial begin
    // edge latch, hold after line drops, acknowledge
    v(8'h08, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h08, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h08, 8'h08, 1);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h08, 8'h08, 1);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h08, 8'h08, 1);
    v(8'h00, 8'hFF, 8'h00, 0, 1, 3, 8'h00, 8'h00, 0);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    // ch5: set, re-trigger coinciding with ack (set wins), then separate ack
    v(8'h20, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h20, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h20, 8'hFF, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1);
    v(8'h20, 8'hFF, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1);
    v(8'h20, 8'hFF, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1);
    v(8'h20, 8'hFF, 8'h00, 0, 1, 5, 8'h20, 8'h20, 1);
    v(8'h20, 8'hFF, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1);
    v(8'h20, 8'hFF, 8'h00, 0, 1, 5, 8'h00, 8'h00, 0);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    // level mode with mask, drop ch7, ack on level ignored, unmask
    v(8'h81, 8'h00, 8'h0F, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h81, 8'h00, 8'h0F, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h81, 8'h00, 8'h0F, 0, 0, 0, 8'h81, 8'h80, 1);
    v(8'h01, 8'h00, 8'h0F, 0, 0, 0, 8'h81, 8'h80, 1);
    v(8'h01, 8'h00, 8'h0F, 0, 0, 0, 8'h81, 8'h80, 1);
    v(8'h01, 8'h00, 8'h0F, 0, 0, 0, 8'h01, 8'h00, 0);
    v(8'h01, 8'h00, 8'h0F, 0, 1, 0, 8'h01, 8'h00, 0);
    v(8'h01, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h01, 1);
    // init_clr re-arm with ch0 held high
    v(8'h01, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);
    v(8'h01, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h01, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h00, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h01, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h01, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    v(8'h01, 8'hFF, 8'h00, 0, 0, 0, 8'h01, 8'h01, 1);
    v(8'h01, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);

    b8.irq_in = 8'hFF; b8.edge_mode = 8'h00; b8.imr = 8'h00;
    b8.init_clr = 0; b8.ack_valid = 0; b8.ack_id = 0;
    b5.irq_in = 0; b5.edge_mode = 0; b5.imr = 0;
    b5.init_clr = 0; b5.ack_valid = 0; b5.ack_id = 0;
    repeat (2) @(negedge clk);
    chk8("reset held", 8'h00, 8'h00, 0);
    reset = 0;
    @(negedge clk);
    chk8("release+1", 8'h00, 8'h00, 0);
    @(negedge clk);
    chk8("release+2", 8'h00, 8'h00, 0);
    @(negedge clk);
    chk8("release+3", 8'hFF, 8'hFF, 1);

    reset = 1;
    b8.irq_in = 8'h00;
    @(negedge clk);
    reset = 0;
    foreach (tv[r]) begin
      b8.irq_in = tv[r].irq; b8.edge_mode = tv[r].em; b8.imr = tv[r].imr;
      b8.init_clr = tv[r].ic; b8.ack_valid = tv[r].av; b8.ack_id = tv[r].aid;
      @(negedge clk);
      chk8($sformatf("vec%0d", r), tv[r].e_irr, tv[r].e_msk, tv[r].e_pnd);
    end
    b8.init_clr = 0; b8.ack_valid = 0;

    b5.edge_mode = 5'h1F;
    b5.irq_in = 5'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("n5 edge+%0d", k + 1), 32'(b5.irr), 32'h0);
    end
    @(negedge clk);
    chk("n5 edge+4", 32'(b5.irr), 32'h10);
    b5.ack_valid = 1;
    b5.ack_id = 3'd6;
    @(negedge clk);
    chk("n5 ack6", 32'(b5.irr), 32'h10);
    b5.ack_id = 3'd4;
    @(negedge clk);
    chk("n5 ack4", 32'(b5.irr), 32'h00);
    chk("n5 pending", 32'(b5.irq_pending), 32'h0);
    b5.ack_valid = 0;

    for (int c = 0; c < 400; c++) begin
      b8.irq_in = b8.irq_in ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) b8.edge_mode = 8'($urandom);
      b8.imr = 8'($urandom);
      b8.init_clr = $urandom_range(0, 31) == 0;
      b8.ack_valid = $urandom_range(0, 1) == 1;
      b8.ack_id = 3'($urandom);
      @(negedge clk);
      chk8($sformatf("rnd%0d", c), m_req, m_req & ~b8.imr, |(m_req & ~b8.imr));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
